// File: rtl/xadc_drp_scanner.sv
// xadc_drp_scanner: round-robin XADC DRP reader issuing one channel read per end-of-conversion.
// Optional build macro XADC_SCAN_AVG_EN enables per-channel 4-sample averaging.
module xadc_drp_scanner #(
    parameter int                        NUM_CH      = 2,
    parameter int                        ADDR_W      = 7,
    parameter int                        SAMPLE_W    = 12,
    parameter logic [NUM_CH*ADDR_W-1:0]  CH_ADDRS    = {7'h1b, 7'h13},
    parameter int                        TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         eoc,
    output logic                         drp_den,
    output logic [ADDR_W-1:0]            drp_daddr,
    input  logic                         drp_drdy,
    input  logic [15:0]                  drp_do,
    output logic [NUM_CH*SAMPLE_W-1:0]   samples,
    output logic [NUM_CH-1:0]            sample_valid,
    output logic                         frame_done,
    output logic                         timeout_err,
    output logic                         overrun,
    output logic [1:0]                   dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_ADVANCE = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    to_cnt;
    logic [ADDR_W-1:0]   addr_sel;
    logic [SAMPLE_W-1:0] cap;
    logic                start;
    logic                rd_ok;
    logic                to_hit;
    logic                last_ch;
    logic                unused_do;

    // DRP handshake: drp_den is a single-cycle request with drp_daddr valid in that
    // cycle; the single drp_drdy that completes it is honoured only while in WAIT.
    assign start     = (state == S_IDLE) && enable && eoc;
    assign rd_ok     = (state == S_WAIT) && drp_drdy;
    assign to_hit    = (state == S_WAIT) && !drp_drdy && (to_cnt == CNT_W'(TIMEOUT_CYC));
    assign last_ch   = (idx == IDX_W'(NUM_CH - 1));
    assign cap       = drp_do[15 -: SAMPLE_W];
    assign unused_do = ^drp_do;

    always_comb begin
        addr_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                addr_sel = CH_ADDRS[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable && eoc) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    if (drp_drdy || to_hit) state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        drp_den     = (state == S_ISSUE);
        timeout_err = to_hit;
        frame_done  = (state == S_ADVANCE) && last_ch;
        dbg_state   = state;
    end

    // Address is latched on the accept edge so it is already valid during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drp_daddr <= '0;
        end else if (start) begin
            drp_daddr <= addr_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_ISSUE) begin
            to_cnt <= '0;
        end else if ((state == S_WAIT) && !drp_drdy && !to_hit) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (state == S_ADVANCE) begin
            idx <= last_ch ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (eoc && (state != S_IDLE)) begin
            overrun <= 1'b1;
        end
    end

`ifdef XADC_SCAN_AVG_EN
    logic [SAMPLE_W+1:0] acc     [NUM_CH];
    logic [1:0]          acc_cnt [NUM_CH];
    logic [SAMPLE_W+1:0] acc_sum;
    logic [1:0]          cnt_sel;

    always_comb begin
        acc_sum = '0;
        cnt_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                acc_sum = acc[k] + {2'b00, cap};
                cnt_sel = acc_cnt[k];
            end
        end
    end

    // Every fourth good read publishes the mean; timeouts leave acc and count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples      <= '0;
            sample_valid <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k]     <= '0;
                acc_cnt[k] <= '0;
            end
        end else begin
            sample_valid <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_ok && (idx == IDX_W'(k))) begin
                    if (cnt_sel == 2'd3) begin
                        samples[k*SAMPLE_W +: SAMPLE_W] <= acc_sum[SAMPLE_W+1:2];
                        sample_valid[k]                 <= 1'b1;
                        acc[k]                          <= '0;
                        acc_cnt[k]                      <= '0;
                    end else begin
                        acc[k]     <= acc_sum;
                        acc_cnt[k] <= cnt_sel + 2'd1;
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples      <= '0;
            sample_valid <= '0;
        end else begin
            sample_valid <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_ok && (idx == IDX_W'(k))) begin
                    samples[k*SAMPLE_W +: SAMPLE_W] <= cap;
                    sample_valid[k]                 <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// Bench for xadc_drp_scanner: three instances (2ch default, 3ch, 1ch) driven by DRP
// transactions and compared with a transaction-level model plus directed vectors.
`timescale 1ns/1ps
module tb_xadc_drp_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [2:0]  en_v, eoc_v, drdy_v;
    logic [15:0] do_v [3];

    logic        den_a, den_b, den_c, fd_a, fd_b, fd_c, te_a, te_b, te_c, ov_a, ov_b, ov_c, sv_c;
    logic [6:0]  addr_a, addr_b, addr_c;
    logic [23:0] samp_a;
    logic [35:0] samp_b;
    logic [11:0] samp_c;
    logic [1:0]  sv_a, st_a, st_b, st_c;
    logic [2:0]  sv_b;

    logic [2:0]  den_v, fd_v, te_v, ov_v;
    logic [6:0]  addr_v [3];
    logic [47:0] samp_v [3];
    logic [2:0]  sv_v [3];
    logic [1:0]  st_v [3];

    assign den_v = {den_c, den_b, den_a};
    assign fd_v  = {fd_c, fd_b, fd_a};
    assign te_v  = {te_c, te_b, te_a};
    assign ov_v  = {ov_c, ov_b, ov_a};
    assign addr_v[0] = addr_a;  assign addr_v[1] = addr_b;  assign addr_v[2] = addr_c;
    assign samp_v[0] = {24'b0, samp_a};  assign samp_v[1] = {12'b0, samp_b};  assign samp_v[2] = {36'b0, samp_c};
    assign sv_v[0] = {1'b0, sv_a};  assign sv_v[1] = sv_b;  assign sv_v[2] = {2'b0, sv_c};
    assign st_v[0] = st_a;  assign st_v[1] = st_b;  assign st_v[2] = st_c;

    xadc_drp_scanner dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_v[0]), .eoc(eoc_v[0]), .drp_den(den_a), .drp_daddr(addr_a),
        .drp_drdy(drdy_v[0]), .drp_do(do_v[0]), .samples(samp_a), .sample_valid(sv_a), .frame_done(fd_a),
        .timeout_err(te_a), .overrun(ov_a), .dbg_state(st_a));

    xadc_drp_scanner #(.NUM_CH(3), .CH_ADDRS({7'h12, 7'h11, 7'h10})) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_v[1]), .eoc(eoc_v[1]), .drp_den(den_b), .drp_daddr(addr_b),
        .drp_drdy(drdy_v[1]), .drp_do(do_v[1]), .samples(samp_b), .sample_valid(sv_b), .frame_done(fd_b),
        .timeout_err(te_b), .overrun(ov_b), .dbg_state(st_b));

    xadc_drp_scanner #(.NUM_CH(1), .CH_ADDRS(7'h05)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(en_v[2]), .eoc(eoc_v[2]), .drp_den(den_c), .drp_daddr(addr_c),
        .drp_drdy(drdy_v[2]), .drp_do(do_v[2]), .samples(samp_c), .sample_valid(sv_c), .frame_done(fd_c),
        .timeout_err(te_c), .overrun(ov_c), .dbg_state(st_c));

    int n_checks = 0;
    int n_fail   = 0;
    int den_cnt [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) if (den_v[i]) den_cnt[i]++;
    end

    // Reference model: per-instance channel pointer, published samples, averaging state.
    int         nch [3] = '{2, 3, 1};
    logic [6:0] addr_tab [3][3];
    int         m_idx [3];
    int         m_samp [3][3];
    int         m_acc [3][3];
    int         m_cnt [3][3];

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_idx[s] = 0;
            for (int k = 0; k < 3; k++) begin
                m_samp[s][k] = 0; m_acc[s][k] = 0; m_cnt[s][k] = 0;
            end
        end
    endtask

    task automatic model_step(input int sel, input bit ok, input logic [15:0] data,
                              output logic [6:0] ea, output logic [2:0] esv, output bit efd);
        int k;
        int v;
        k   = m_idx[sel];
        v   = int'(data) / 16;
        ea  = addr_tab[sel][k];
        esv = '0;
        if (ok) begin
`ifdef XADC_SCAN_AVG_EN
            m_acc[sel][k] += v;
            m_cnt[sel][k] += 1;
            if (m_cnt[sel][k] == 4) begin
                m_samp[sel][k] = m_acc[sel][k] / 4;
                esv[k] = 1'b1;
                m_acc[sel][k] = 0;
                m_cnt[sel][k] = 0;
            end
`else
            m_samp[sel][k] = v;
            esv[k] = 1'b1;
`endif
        end
        efd = (k == nch[sel] - 1);
        m_idx[sel] = (k + 1) % nch[sel];
    endtask

    function automatic logic [47:0] exp_samp(input int sel);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < nch[sel]; k++) r[k*12 +: 12] = 12'(m_samp[sel][k]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_zero(input int sel);
        check("rst_den",   den_v[sel], 0);
        check("rst_addr",  addr_v[sel], 0);
        check("rst_samp",  samp_v[sel], 0);
        check("rst_sv",    sv_v[sel], 0);
        check("rst_fd",    fd_v[sel], 0);
        check("rst_te",    te_v[sel], 0);
        check("rst_ov",    ov_v[sel], 0);
        check("rst_state", st_v[sel], 0);
    endtask

    // One eoc-triggered read; give=0 withholds drdy to force a timeout.
    task automatic txn(input int sel, input bit give, input int delay, input logic [15:0] data,
                       input bit eoc_again, output logic [6:0] got_addr, output logic [2:0] got_sv,
                       output logic [47:0] got_samp, output bit got_fd);
        logic [6:0] ea;
        logic [2:0] esv;
        logic [2:0] stray;
        bit         efd;
        int         k;
        int         den0;
        model_step(sel, give, data, ea, esv, efd);
        stray = '0;
        den0  = den_cnt[sel];
        @(negedge clk); eoc_v[sel] = 1'b1;
        @(negedge clk); eoc_v[sel] = 1'b0;
        check("den_pulse", den_v[sel], 1);
        got_addr = addr_v[sel];
        check("issue_addr", got_addr, ea);
        @(negedge clk);
        k = 1;
        if (eoc_again) begin
            eoc_v[sel] = 1'b1;
            @(negedge clk); eoc_v[sel] = 1'b0;
            k = 2;
        end
        if (give) begin
            repeat (delay) begin stray |= sv_v[sel]; @(negedge clk); end
            stray |= sv_v[sel];
            drdy_v[sel] = 1'b1; do_v[sel] = data;
            @(negedge clk); drdy_v[sel] = 1'b0;
            got_sv = sv_v[sel]; got_fd = fd_v[sel]; got_samp = samp_v[sel];
            check("hold_addr", addr_v[sel], ea);
            check("stray_valid", stray, 0);
        end else begin
            while (!te_v[sel] && k < 200) begin stray |= sv_v[sel]; @(negedge clk); k++; end
            check("timeout_cycles", k, 65);
            stray |= sv_v[sel];
            @(negedge clk);
            got_sv = stray | sv_v[sel]; got_fd = fd_v[sel]; got_samp = samp_v[sel];
        end
        @(negedge clk);
        check("sample_valid", got_sv, esv);
        check("frame_done", got_fd, efd);
        check("samples", got_samp, exp_samp(sel));
        check("den_count", den_cnt[sel] - den0, 1);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic [6:0]  addr;
        logic [2:0]  sv;
        int          k;
        logic [11:0] sval;
        bit          fd;
    } vec_t;
    vec_t tab [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  ga;
        logic [2:0]  gsv;
        logic [47:0] gs;
        bit          gfd;
        int          d0;

        addr_tab[0][0] = 7'h13; addr_tab[0][1] = 7'h1b; addr_tab[0][2] = 7'h00;
        addr_tab[1][0] = 7'h10; addr_tab[1][1] = 7'h11; addr_tab[1][2] = 7'h12;
        addr_tab[2][0] = 7'h05; addr_tab[2][1] = 7'h00; addr_tab[2][2] = 7'h00;
        model_reset();

        tab[0] = '{0, 16'hABC0, 7'h13, 3'b001, 0, 12'hABC, 1'b0};
        tab[1] = '{0, 16'h5670, 7'h1b, 3'b010, 1, 12'h567, 1'b1};
        for (int i = 0; i < 4; i++) begin
`ifdef XADC_SCAN_AVG_EN
            tab[2+i] = '{2, 16'(16'h1000 * (i + 1)), 7'h05, (i == 3) ? 3'b001 : 3'b000, 0, 12'h280, 1'b1};
`else
            tab[2+i] = '{2, 16'(16'h1000 * (i + 1)), 7'h05, 3'b001, 0, 12'(12'h100 * (i + 1)), 1'b1};
`endif
        end
        for (int i = 0; i < 7; i++) begin
            tab[6+i].sel  = 1;
            tab[6+i].data = 16'(16'h1000 * (i + 1) + 16'h0050);
            tab[6+i].addr = 7'(7'h10 + i % 3);
            tab[6+i].k    = i % 3;
            tab[6+i].sval = 12'(tab[6+i].data >> 4);
            tab[6+i].fd   = (i % 3 == 2);
`ifdef XADC_SCAN_AVG_EN
            tab[6+i].sv   = 3'b000;
`else
            tab[6+i].sv   = 3'(1 << (i % 3));
`endif
        end

        rst_n = 1'b0; en_v = '0; eoc_v = '0; drdy_v = '0;
        for (int i = 0; i < 3; i++) do_v[i] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) check_zero(s);
        rst_n = 1'b1; en_v = 3'b111;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            txn(tab[i].sel, 1'b1, 1, tab[i].data, 1'b0, ga, gsv, gs, gfd);
            check("vec_addr", ga, tab[i].addr);
            check("vec_sv", gsv, tab[i].sv);
            check("vec_fd", gfd, tab[i].fd);
            if (tab[i].sv != 0) check("vec_sample", gs[tab[i].k*12 +: 12], tab[i].sval);
        end
        check("two_ch_samples", samp_a, 24'h567ABC);

        // Channel pointer is at 1 after seven reads: time out the 0x11 read, then 0x12 follows.
        txn(1, 1'b0, 0, 16'h0000, 1'b0, ga, gsv, gs, gfd);
        check("to_addr", ga, 7'h11);
        txn(1, 1'b1, 2, 16'h7770, 1'b0, ga, gsv, gs, gfd);
        check("after_to_addr", ga, 7'h12);

        d0 = den_cnt[1];
        en_v[1] = 1'b0;
        @(negedge clk); eoc_v[1] = 1'b1;
        @(negedge clk); eoc_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("disabled_den", den_cnt[1] - d0, 0);
        check("disabled_ov", ov_v[1], 0);
        en_v[1] = 1'b1;

        @(negedge clk); drdy_v[1] = 1'b1; do_v[1] = 16'hFFF0;
        @(negedge clk); drdy_v[1] = 1'b0;
        check("idle_drdy_sv", sv_v[1], 0);
        check("idle_drdy_samp", samp_v[1], exp_samp(1));

        txn(1, 1'b1, 2, 16'h4440, 1'b1, ga, gsv, gs, gfd);
        check("overrun_set", ov_v[1], 1);

        for (int i = 0; i < 30; i++) begin
            txn($urandom_range(0, 2), ($urandom_range(0, 9) != 0), $urandom_range(0, 6),
                16'($urandom), 1'b0, ga, gsv, gs, gfd);
        end
        check("overrun_sticky", ov_v[1], 1);

        @(negedge clk); eoc_v[1] = 1'b1;
        @(negedge clk); eoc_v[1] = 1'b0;
        @(negedge clk);
        check("pre_rst_state", st_v[1], 2);
        #2 rst_n = 1'b0;
        #1 check_zero(1);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        txn(1, 1'b1, 0, 16'h9990, 1'b0, ga, gsv, gs, gfd);
        check("post_rst_addr", ga, 7'h10);
        check("post_rst_ov", ov_v[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
